// File: rtl/edge_timestamp_fifo.sv
// Edge event timestamp FIFO: captures rising/falling events with a free-running
// timestamp into a small registered FIFO. Define EDGE_TS_LOST_CNT_EN for the lost-event counter.
module edge_timestamp_fifo #(
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    r_edge_i,
    input  logic                    f_edge_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    edge_o,
    output logic [TS_WIDTH-1:0]     ts_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic [7:0]              lost_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_WIDTH-1:0] ts_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                valid_q;
    logic                overflow_q;

    logic                edge_mem [DEPTH];
    logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

    logic          event_v;
    logic          pop;
    logic          full;
    logic          push;
    logic          reject;
    logic [CW-1:0] count_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        event_v    = en_i & (r_edge_i | f_edge_i);
        pop        = valid_q & ready_i;
        full       = (count_q == CW'(DEPTH));
        // A full FIFO still takes the event when the head leaves in the same cycle.
        push       = event_v & (~full | pop);
        reject     = event_v & ~push;
        count_next = count_q;
        if (push && !pop)      count_next = count_q + CW'(1);
        else if (pop && !push) count_next = count_q - CW'(1);
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clr_i) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (en_i) ts_q     <= ts_q + TS_WIDTH'(1);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_next;
            valid_q <= (count_next != '0);
            if (reject) overflow_q <= 1'b1;
        end
    end

    // NOTE: storage has no reset; valid_q and the pointers alone decide what is meaningful.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            edge_mem[wr_ptr_q] <= r_edge_i;
            ts_mem[wr_ptr_q]   <= ts_q;
        end
    end

`ifdef EDGE_TS_LOST_CNT_EN
    logic [7:0] lost_q;
    logic [1:0] lost_inc;
    logic [8:0] lost_sum;

    // A collision drops the falling event; a full-FIFO reject drops the rising one too.
    always_comb begin
        lost_inc = {1'b0, reject} + {1'b0, en_i & r_edge_i & f_edge_i};
        lost_sum = {1'b0, lost_q} + {7'd0, lost_inc};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lost_q <= '0;
        end else if (clr_i) begin
            lost_q <= '0;
        end else if (lost_sum[8]) begin
            lost_q <= 8'hFF;
        end else begin
            lost_q <= lost_sum[7:0];
        end
    end

    assign lost_cnt_o = lost_q;
`else
    assign lost_cnt_o = '0;
`endif

    assign valid_o    = valid_q;
    assign edge_o     = edge_mem[rd_ptr_q];
    assign ts_o       = ts_mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_edge_timestamp_fifo.sv
// Scoreboard bench for edge_timestamp_fifo (DEPTH=4, TS_WIDTH=4 so counter wrap is reachable).
module tb_edge_timestamp_fifo;

    localparam int DEPTH = 4;
    localparam int TSW   = 4;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           en_i = 1'b0, clr_i = 1'b0, r_edge_i = 1'b0, f_edge_i = 1'b0, ready_i = 1'b0;
    logic           valid_o, edge_o, overflow_o;
    logic [TSW-1:0] ts_o;
    logic [2:0]     count_o;
    logic [7:0]     lost_cnt_o;

    edge_timestamp_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
        .r_edge_i(r_edge_i), .f_edge_i(f_edge_i), .valid_o(valid_o), .ready_i(ready_i),
        .edge_o(edge_o), .ts_o(ts_o), .count_o(count_o), .overflow_o(overflow_o),
        .lost_cnt_o(lost_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic           e;
        logic [TSW-1:0] ts;
    } entry_t;

    entry_t sb[$];
    int     m_ts, m_lost;
    logic   m_ovf;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic model_reset();
        sb.delete();
        m_ts = 0; m_lost = 0; m_ovf = 1'b0;
    endtask

    // Drive one cycle; the head is compared against the scoreboard whenever a pop is expected.
    task automatic step(input logic en, input logic r, input logic f, input logic rdy, input logic clr);
        logic   pop, ev, push, rej, coll;
        entry_t exp_e;
        en_i = en; r_edge_i = r; f_edge_i = f; ready_i = rdy; clr_i = clr;
        pop = (sb.size() != 0) && rdy;
        if (pop && !clr) begin
            exp_e = sb.pop_front();
            n_cmp++;
            if (edge_o !== exp_e.e || ts_o !== exp_e.ts) begin
                n_err++;
                $display("FAIL pop_head: got edge=%0b ts=%0d want edge=%0b ts=%0d",
                         edge_o, ts_o, exp_e.e, exp_e.ts);
            end
        end
        if (clr) begin
            model_reset();
        end else begin
            ev   = en && (r || f);
            push = ev && ((sb.size() < DEPTH) || pop);
            rej  = ev && !push;
            coll = en && r && f;
            if (push) sb.push_back('{e: r, ts: TSW'(m_ts)});
            if (rej) m_ovf = 1'b1;
`ifdef EDGE_TS_LOST_CNT_EN
            m_lost = m_lost + int'(rej) + int'(coll);
            if (m_lost > 255) m_lost = 255;
`endif
            if (en) m_ts = (m_ts + 1) % (1 << TSW);
        end
        @(posedge clk_i); #1;
        en_i = 1'b0; r_edge_i = 1'b0; f_edge_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) step(0, 0, 0, 1, 0);
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: got valid=%0b count=%0d want valid=0 count=0", valid_o, count_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== 3'd0 || overflow_o !== 1'b0 || lost_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%0b count=%0d ovf=%0b lost=%0d want all 0",
                     valid_o, count_o, overflow_o, lost_cnt_o);
        end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_first_event();
        repeat (5) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || edge_o !== 1'b1 || ts_o !== 4'd5 || count_o !== 3'd1) begin
            n_err++;
            $display("FAIL first_event: got valid=%0b edge=%0b ts=%0d count=%0d want 1 1 5 1",
                     valid_o, edge_o, ts_o, count_o);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) step(1, (i % 2) == 0, (i % 2) == 1, 0, 0);
        n_cmp++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_flags: got count=%0d ovf=%0b want count=4 ovf=1", count_o, overflow_o);
        end
        n_cmp++;
        if (lost_cnt_o !== 8'(m_lost)) begin
            n_err++;
            $display("FAIL overflow_lost: got %0d want %0d", lost_cnt_o, m_lost);
        end
        drain();
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (overflow_o !== 1'b0 || lost_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL clr_flags: got ovf=%0b lost=%0d want 0 0", overflow_o, lost_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        repeat (DEPTH) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        n_cmp++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: got count=%0d ovf=%0b want count=4 ovf=0", count_o, overflow_o);
        end
        drain();
        step(1, 1, 1, 0, 0);
        n_cmp++;
        if (count_o !== 3'd1 || overflow_o !== 1'b0 || edge_o !== 1'b1 || lost_cnt_o !== 8'(m_lost)) begin
            n_err++;
            $display("FAIL collision_not_full: got count=%0d ovf=%0b edge=%0b lost=%0d want 1 0 1 %0d",
                     count_o, overflow_o, edge_o, lost_cnt_o, m_lost);
        end
        repeat (DEPTH - 1) step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        n_cmp++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL collision_full: got count=%0d ovf=%0b want count=4 ovf=1", count_o, overflow_o);
        end
        drain();
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_wrap();
        int lost_before;
        repeat (15) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        n_cmp++;
        if (ts_o !== 4'd15 || edge_o !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_head: got ts=%0d edge=%0b want ts=15 edge=1", ts_o, edge_o);
        end
        step(1, 0, 1, 0, 0);
        lost_before = m_lost;
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        n_cmp++;
        if (count_o !== 3'd3 || lost_cnt_o !== 8'(lost_before)) begin
            n_err++;
            $display("FAIL en_low_ignored: got count=%0d lost=%0d want count=3 lost=%0d",
                     count_o, lost_cnt_o, lost_before);
        end
        drain();
    endtask

    task automatic test_clear_and_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        n_cmp++;
        if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: got count=%0d valid=%0b want 0 0", count_o, valid_o);
        end
        step(1, 1, 0, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || ts_o !== 4'd0) begin
            n_err++;
            $display("FAIL clr_counter: got valid=%0b ts=%0d want valid=1 ts=0", valid_o, ts_o);
        end
        step(1, 0, 1, 0, 0);
        rst_i = 1'b1;
        #2;
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%0b count=%0d want 0 0", valid_o, count_o);
        end
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        step(1, 0, 1, 0, 0);
        n_cmp++;
        if (valid_o !== 1'b1 || edge_o !== 1'b0 || ts_o !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset_event: got valid=%0b edge=%0b ts=%0d want 1 0 0", valid_o, edge_o, ts_o);
        end
        drain();
    endtask

    task automatic test_saturate();
        repeat (DEPTH + 260) step(1, 1, 0, 0, 0);
        n_cmp++;
        if (overflow_o !== 1'b1 || lost_cnt_o !== 8'(m_lost)) begin
            n_err++;
            $display("FAIL lost_saturate: got ovf=%0b lost=%0d want ovf=1 lost=%0d", overflow_o, lost_cnt_o, m_lost);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_clear_and_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
